// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//
// Purpose:
//   Parametrised serial pattern detector. On every qualified cycle a single
//   serial bit is shifted into a history register and the most recent N bits
//   are compared against a pattern register that can be reloaded at run time.
//   Each hit produces a one-cycle registered pulse and bumps a saturating hit
//   counter. Overlapping or non-overlapping detection is selected per cycle.
//
// Parameters:
//   N         pattern length in bits (2..32)
//   CW        hit counter width in bits (>= 1)
//   RESET_PAT pattern register value after reset
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-low reset
//   en         in   1   sample qualifier; 'in' consumed only when en=1
//   in         in   1   serial data bit
//   overlap    in   1   1 = overlapping detection, 0 = non-overlapping
//   pat_load   in   1   load pat_i, flush history; overrides sampling
//   pat_i      in   N   new pattern
//   clear_cnt  in   1   synchronous clear of the hit counter
//   q          out  1   registered match pulse
//   cnt        out  CW  saturating hit count
//   pat_o      out  N   current pattern register
// ---------------------------------------------------------------------------
module seq_detector_param #(
  parameter int unsigned     N         = 3,
  parameter int unsigned     CW        = 8,
  parameter logic [N-1:0]    RESET_PAT = N'(3'b111)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in,
  input  logic          overlap,
  input  logic          pat_load,
  input  logic [N-1:0]  pat_i,
  input  logic          clear_cnt,
  output logic          q,
  output logic [CW-1:0] cnt,
  output logic [N-1:0]  pat_o
);

  // The fill counter must be able to hold the value N itself.
  localparam int unsigned FW = $clog2(N + 1);

  localparam logic [FW-1:0] FILL_FULL = FW'(N);
  localparam logic [FW-1:0] FILL_MIN  = FW'(N - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  logic [N-1:0]  r_hist;
  logic [FW-1:0] r_fill;
  logic [N-1:0]  r_pat;
  logic          r_q;
  logic [CW-1:0] r_cnt;

  logic          w_sample;
  logic [N-1:0]  w_shift;
  logic          w_match;

  // A pattern load takes priority over sampling, so a cycle only counts as a
  // sample when en is high and no load is in progress.
  assign w_sample = en & ~pat_load;

  // The window the incoming bit would complete: oldest bit lands in the MSB
  // and is compared against pat[N-1], the new bit against pat[0].
  assign w_shift = {r_hist[N-2:0], in};

  // The history must already hold N-1 valid bits so that, together with the
  // incoming bit, a full window of real samples is being compared.
  assign w_match = w_sample && (w_shift == r_pat) && (r_fill >= FILL_MIN);

  // Pattern, history, fill level and the match pulse.
  // After a hit the fill level decides whether the next hit may reuse bits:
  // staying saturated allows overlap, dropping to zero demands N fresh bits.
  // Idle cycles (en=0) freeze the history so gaps do not break a sequence,
  // but the pulse is always cleared so it lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat  <= RESET_PAT;
      r_hist <= '0;
      r_fill <= '0;
      r_q    <= 1'b0;
    end else if (pat_load) begin
      r_pat  <= pat_i;
      r_hist <= '0;
      r_fill <= '0;
      r_q    <= 1'b0;
    end else if (en) begin
      r_hist <= w_shift;
      r_q    <= w_match;
      if (w_match) begin
        r_fill <= overlap ? FILL_FULL : '0;
      end else if (r_fill != FILL_FULL) begin
        r_fill <= r_fill + FW'(1);
      end
    end else begin
      r_q <= 1'b0;
    end
  end

  // Saturating hit counter. A clear that coincides with a hit restarts the
  // count at one so that the hit in that very cycle is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear_cnt) begin
      r_cnt <= w_match ? CW'(1) : '0;
    end else if (w_match && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign q     = r_q;
  assign cnt   = r_cnt;
  assign pat_o = r_pat;

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//
// Directed bench for seq_detector_param. Two instances share all inputs:
// the default configuration (N=3, CW=8) and a narrow-counter one (CW=2)
// used to observe counter saturation.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in;
  logic       overlap;
  logic       pat_load;
  logic [2:0] pat_i;
  logic       clear_cnt;

  logic       q;
  logic [7:0] cnt;
  logic [2:0] pat_o;

  logic       qSat;
  logic [1:0] cntSat;
  logic [2:0] patSat;

  int errors = 0;
  int checks = 0;

  seq_detector_param #(.N(3), .CW(8), .RESET_PAT(3'b111)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .overlap(overlap),
    .pat_load(pat_load), .pat_i(pat_i), .clear_cnt(clear_cnt),
    .q(q), .cnt(cnt), .pat_o(pat_o)
  );

  seq_detector_param #(.N(3), .CW(2), .RESET_PAT(3'b111)) dutSat (
    .clk(clk), .rst(rst), .en(en), .in(in), .overlap(overlap),
    .pat_load(pat_load), .pat_i(pat_i), .clear_cnt(clear_cnt),
    .q(qSat), .cnt(cntSat), .pat_o(patSat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs on the falling edge, then settle just past the
  // following rising edge so outputs reflect that cycle.
  task automatic step(input logic e, input logic b, input logic ld,
                      input logic [2:0] p, input logic clr);
    @(negedge clk);
    en = e; in = b; pat_load = ld; pat_i = p; clear_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (q !== 1'b0) begin errors++; $display("[TB] FAIL reset_q got=%b want=0", q); end
    checks++;
    if (cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt got=%0d want=0", cnt); end
    checks++;
    if (pat_o !== 3'b111) begin errors++; $display("[TB] FAIL reset_pat got=%b want=111", pat_o); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_overlap;
    logic [4:0] expQ;
    expQ = 5'b11100;
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 3'b111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      checks++;
      if (q !== expQ[i]) begin errors++; $display("[TB] FAIL overlap_q bit=%0d got=%b want=%b", i + 1, q, expQ[i]); end
    end
    checks++;
    if (cnt !== 8'd3) begin errors++; $display("[TB] FAIL overlap_cnt got=%0d want=3", cnt); end
  endtask

  task automatic test_nonoverlap;
    logic [5:0] expQ;
    expQ = 6'b100100;
    overlap = 1'b0;
    step(1'b0, 1'b0, 1'b1, 3'b111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      checks++;
      if (q !== expQ[i]) begin errors++; $display("[TB] FAIL nonoverlap_q bit=%0d got=%b want=%b", i + 1, q, expQ[i]); end
    end
    checks++;
    if (cnt !== 8'd2) begin errors++; $display("[TB] FAIL nonoverlap_cnt got=%0d want=2", cnt); end
  endtask

  task automatic test_pattern;
    logic [4:0] bits;
    logic [4:0] expOv;
    logic [4:0] expNo;
    bits  = 5'b10101;
    expOv = 5'b10100;
    expNo = 5'b00100;
    overlap = 1'b1;
    // Load with en=1 and in=1 to show the load cycle does not sample.
    step(1'b1, 1'b1, 1'b1, 3'b101, 1'b1);
    checks++;
    if (pat_o !== 3'b101) begin errors++; $display("[TB] FAIL pattern_pat got=%b want=101", pat_o); end
    checks++;
    if (q !== 1'b0) begin errors++; $display("[TB] FAIL pattern_load_q got=%b want=0", q); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bits[4 - i], 1'b0, 3'b000, 1'b0);
      checks++;
      if (q !== expOv[i]) begin errors++; $display("[TB] FAIL pattern_ov_q bit=%0d got=%b want=%b", i + 1, q, expOv[i]); end
    end
    overlap = 1'b0;
    step(1'b0, 1'b0, 1'b1, 3'b101, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bits[4 - i], 1'b0, 3'b000, 1'b0);
      checks++;
      if (q !== expNo[i]) begin errors++; $display("[TB] FAIL pattern_no_q bit=%0d got=%b want=%b", i + 1, q, expNo[i]); end
    end
    checks++;
    if (cnt !== 8'd1) begin errors++; $display("[TB] FAIL pattern_cnt got=%0d want=1", cnt); end
  endtask

  task automatic test_gap;
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 3'b111, 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      checks++;
      if (q !== 1'b0) begin errors++; $display("[TB] FAIL gap_q idle=%0d got=%b want=0", i, q); end
    end
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    checks++;
    if (q !== 1'b1) begin errors++; $display("[TB] FAIL gap_resume_q got=%b want=1", q); end
    checks++;
    if (cnt !== 8'd1) begin errors++; $display("[TB] FAIL gap_cnt got=%0d want=1", cnt); end
  endtask

  task automatic test_saturate;
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 3'b111, 1'b1);
    // Eight ones give six overlapping matches.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    end
    checks++;
    if (cntSat !== 2'd3) begin errors++; $display("[TB] FAIL sat_cnt got=%0d want=3", cntSat); end
    checks++;
    if (cnt !== 8'd6) begin errors++; $display("[TB] FAIL wide_cnt got=%0d want=6", cnt); end
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    checks++;
    if (cntSat !== 2'd3) begin errors++; $display("[TB] FAIL sat_hold got=%0d want=3", cntSat); end
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    checks++;
    if (cntSat !== 2'd1) begin errors++; $display("[TB] FAIL clear_with_match got=%0d want=1", cntSat); end
    checks++;
    if (qSat !== 1'b1) begin errors++; $display("[TB] FAIL clear_with_match_q got=%b want=1", qSat); end
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    checks++;
    if (cntSat !== 2'd0) begin errors++; $display("[TB] FAIL clear_alone got=%0d want=0", cntSat); end
    checks++;
    if (cnt !== 8'd0) begin errors++; $display("[TB] FAIL clear_alone_wide got=%0d want=0", cnt); end
  endtask

  task automatic test_async_reset;
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 3'b110, 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    checks++;
    if (q !== 1'b1) begin errors++; $display("[TB] FAIL prereset_q got=%b want=1", q); end
    // Assert reset between edges while the pulse is high.
    #2;
    en = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (q !== 1'b0) begin errors++; $display("[TB] FAIL async_q got=%b want=0", q); end
    checks++;
    if (cnt !== 8'd0) begin errors++; $display("[TB] FAIL async_cnt got=%0d want=0", cnt); end
    checks++;
    if (pat_o !== 3'b111) begin errors++; $display("[TB] FAIL async_pat got=%b want=111", pat_o); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      checks++;
      if (q !== 1'b0) begin errors++; $display("[TB] FAIL postreset_q bit=%0d got=%b want=0", i + 1, q); end
    end
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    checks++;
    if (q !== 1'b1) begin errors++; $display("[TB] FAIL postreset_match got=%b want=1", q); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_i = 3'b000; clear_cnt = 1'b0;
    test_reset;
    test_overlap;
    test_nonoverlap;
    test_pattern;
    test_gap;
    test_saturate;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector; successor to the fixed three-ones detector FSM.
- Samples a 1-bit serial input on qualified cycles and compares the last N bits against a runtime-loadable pattern.
- Pulses a registered match flag on each hit and keeps a saturating hit counter.
- Supports overlapping and non-overlapping detection, selectable per cycle; used as a building block in serial-protocol front ends.

Parameters:
- N, 3, pattern length in bits; legal range 2..32.
- CW, 8, hit counter width in bits; at least 1.
- RESET_PAT, 3'b111 (N bits), pattern register value after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample qualifier; `in` is consumed only on cycles with en=1.
- in  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection; 0 = non-overlapping.
- pat_load  input  1  load pat_i into the pattern register and flush history.
- pat_i  input  N  new pattern.
- clear_cnt  input  1  synchronous clear of the hit counter.
- q  output  1  match pulse; registered.
- cnt  output  CW  saturating hit count.
- pat_o  output  N  current pattern register.

Behaviour:
- **Reset (rst=0, asynchronous):**
  - hist=0, fill=0, q=0, cnt=0, pat=RESET_PAT.
  - Reset asserted mid-operation drops any partial match immediately.
  - First sample after deassertion is bit 1 of a new sequence.
- **Bit order:** pattern bit pat[N-1] is compared with the oldest of the N bits; pat[0] is compared with the newest.
- **State:**
  - hist[N-1:0] shift register, updated as hist <= {hist[N-2:0], in} on each sample.
  - fill counter 0..N, counting valid bits in hist; saturates at N.
- **Match condition:** evaluated combinationally on a sample cycle (en=1, pat_load=0). Both must hold:
  - {hist[N-2:0], in} == pat
  - fill >= N-1
- **q timing:**
  - q is a flop: q=1 for exactly the one cycle following the edge that sampled the completing bit. Latency is one clock from the last pattern bit.
  - q=0 on every other cycle, including cycles after en=0 or pat_load.
- **After a match:**
  - overlap=1: fill saturates at N, so subsequent matches may share bits with the previous one.
  - overlap=0: fill is set to 0, so the next match needs N fresh bits.
  - hist shifts normally in both modes.
- **en=0:** hist, fill and cnt are held; q=0 on the next cycle. Idle gaps do not break a sequence.
- **pat_load=1:**
  - pat <= pat_i; hist=0, fill=0; q=0 next cycle.
  - Overrides sampling: `in` is ignored that cycle even if en=1.
  - cnt is unaffected.
- **cnt:**
  - Increments on each match.
  - Saturates at 2^CW-1 and holds there; never wraps.
- **clear_cnt=1:** cnt <= 0, except that a simultaneous match gives cnt <= 1, so no hit is lost.
- **Implementation:** no combinational path from inputs to any output; all outputs come from flops or the pattern register.

Test Plan:
- Defaults (N=3, pat=111), overlap=1, en=1, in=1,1,1,1,1 -> q high in the cycles after bits 3, 4 and 5; cnt=3.
- Same input stream with overlap=0, in=1 for six bits -> q after bits 3 and 6 only; cnt=2.
- pat_load with pat_i=101, then overlap=1, in=1,0,1,0,1 -> q after bits 3 and 5; with overlap=0 -> q after bit 3 only; pat_o=101.
- pat=111, in=1,1, then en=0 for 4 cycles with in=0, then en=1, in=1 -> q one cycle later; no q during the gap.
- CW=2, six matches in overlap mode -> cnt=3 and held. Then clear_cnt asserted together with a match -> cnt=1; clear_cnt alone -> cnt=0.
- pat=111, in=1,1, then rst=0 asynchronously between edges -> q=0, cnt=0, pat_o=111 immediately. After release, in=1 -> no q until two more 1s are sampled.
